// File: rtl/res_cycle_sequencer.sv
// Control sequencer for the residue / carry-save stage of the online multiplier.
// Runs ITERS iterations of one CLEAR cycle plus WORDS word-serial RUN cycles.
module res_cycle_sequencer #(
  parameter int RAM_ADDR_WIDTH = 7,
  parameter int WORDS          = 4,
  parameter int ITERS          = 16
) (
  input  logic                      clk,
  input  logic                      asyn_reset_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                carry_out_control,
  output logic                      enable,
  output logic                      enable_shift,
  output logic                      enable_V_reg,
  output logic [RAM_ADDR_WIDTH-1:0] read_addr,
  output logic [RAM_ADDR_WIDTH-1:0] write_addr,
  output logic [RAM_ADDR_WIDTH-1:0] comp_cycle,
  output logic                      operand_req,
  output logic [RAM_ADDR_WIDTH-1:0] operand_word
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam logic [AW-1:0] W_LAST = AW'(WORDS - 1);
  localparam logic [AW-1:0] K_LAST = AW'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [1:0]    cco;
    logic          en;
    logic          en_sh;
    logic          en_v;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [AW-1:0] cc;
    logic          op_req;
    logic [AW-1:0] op_word;
  } ctl_t;

  state_e        state_q, state_d;
  logic [AW-1:0] w_q, w_d;
  logic [AW-1:0] k_q, k_d;
  ctl_t          ctl_q, ctl_d;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_CLEAR;
          w_d     = '0;
          k_d     = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
        w_d     = '0;
      end
      S_RUN: begin
        if (w_q != W_LAST) begin
          w_d = w_q + 1'b1;
        end else if (k_q != K_LAST) begin
          state_d = S_CLEAR;
          w_d     = '0;
          k_d     = k_q + 1'b1;
        end else begin
          state_d = S_DONE;
          w_d     = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        w_d     = '0;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      w_d     = '0;
      k_d     = '0;
    end
  end

  // Outputs are decoded from the next state so they land registered.
  always_comb begin
    ctl_d = '0;
    unique case (state_d)
      S_CLEAR: begin
        ctl_d.busy = 1'b1;
        ctl_d.cc   = k_d;
      end
      S_RUN: begin
        ctl_d.busy    = 1'b1;
        ctl_d.en      = 1'b1;
        ctl_d.en_sh   = 1'b1;
        ctl_d.op_req  = 1'b1;
        ctl_d.op_word = w_d;
        ctl_d.wa      = w_d;
        ctl_d.cc      = k_d;
        if (w_d == W_LAST) begin
          ctl_d.cco  = 2'd2;
          ctl_d.en_v = 1'b1;
          ctl_d.ra   = '0;
        end else begin
          ctl_d.cco = 2'd1;
          ctl_d.ra  = w_d + 1'b1;
        end
      end
      S_DONE: ctl_d.done = 1'b1;
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      k_q     <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy              = ctl_q.busy;
  assign done              = ctl_q.done;
  assign carry_out_control = ctl_q.cco;
  assign enable            = ctl_q.en;
  assign enable_shift      = ctl_q.en_sh;
  assign enable_V_reg      = ctl_q.en_v;
  assign read_addr         = ctl_q.ra;
  assign write_addr        = ctl_q.wa;
  assign comp_cycle        = ctl_q.cc;
  assign operand_req       = ctl_q.op_req;
  assign operand_word      = ctl_q.op_word;

endmodule

// File: tb/tb_res_cycle_sequencer.sv
// Scoreboard bench: default instance (4 words, 16 iters) and a
// small instance (2 words, 1 iter) driven side by side.
module tb_res_cycle_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] cco;
    logic       en;
    logic       esh;
    logic       evr;
    logic [6:0] ra;
    logic [6:0] wa;
    logic [6:0] cc;
    logic       oreq;
    logic [6:0] ow;
  } vec_t;

  typedef struct {
    vec_t v;
    int   c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sa, aa, sb, ab;

  logic       a_busy, a_done, a_en, a_esh, a_evr, a_oreq;
  logic [1:0] a_cco;
  logic [6:0] a_ra, a_wa, a_cc, a_ow;
  logic       b_busy, b_done, b_en, b_esh, b_evr, b_oreq;
  logic [1:0] b_cco;
  logic [6:0] b_ra, b_wa, b_cc, b_ow;

  int n_chk  = 0;
  int n_pass = 0;
  int ca = 0;
  int cb = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  res_cycle_sequencer dut_a (
    .clk(clk), .asyn_reset_n(rst_n),
    .start(sa), .abort(aa),
    .busy(a_busy), .done(a_done),
    .carry_out_control(a_cco),
    .enable(a_en), .enable_shift(a_esh),
    .enable_V_reg(a_evr),
    .read_addr(a_ra), .write_addr(a_wa),
    .comp_cycle(a_cc),
    .operand_req(a_oreq), .operand_word(a_ow)
  );

  res_cycle_sequencer #(
    .RAM_ADDR_WIDTH(7), .WORDS(2), .ITERS(1)
  ) dut_b (
    .clk(clk), .asyn_reset_n(rst_n),
    .start(sb), .abort(ab),
    .busy(b_busy), .done(b_done),
    .carry_out_control(b_cco),
    .enable(b_en), .enable_shift(b_esh),
    .enable_V_reg(b_evr),
    .read_addr(b_ra), .write_addr(b_wa),
    .comp_cycle(b_cc),
    .operand_req(b_oreq), .operand_word(b_ow)
  );

  function automatic vec_t get_a();
    return {a_busy, a_done, a_cco, a_en, a_esh,
            a_evr, a_ra, a_wa, a_cc, a_oreq, a_ow};
  endfunction

  function automatic vec_t get_b();
    return {b_busy, b_done, b_cco, b_en, b_esh,
            b_evr, b_ra, b_wa, b_cc, b_oreq, b_ow};
  endfunction

  // Expected outputs in cycle c of an operation (c=0: idle).
  function automatic vec_t model(int c, int W, int I);
    vec_t v;
    int   last, k, p, w;
    v    = '0;
    last = I * (W + 1) + 1;
    if (c >= 1 && c < last) begin
      k      = (c - 1) / (W + 1);
      p      = (c - 1) % (W + 1);
      v.busy = 1'b1;
      v.cc   = 7'(k);
      if (p > 0) begin
        w      = p - 1;
        v.en   = 1'b1;
        v.esh  = 1'b1;
        v.oreq = 1'b1;
        v.ow   = 7'(w);
        v.wa   = 7'(w);
        v.ra   = (w == W - 1) ? 7'd0 : 7'(w + 1);
        v.cco  = (w == W - 1) ? 2'd2 : 2'd1;
        v.evr  = (w == W - 1);
      end
    end else if (c == last) begin
      v.done = 1'b1;
    end
    return v;
  endfunction

  function automatic int adv(int c, bit s, bit a,
                             int W, int I);
    if (a) return 0;
    if (c == 0) return s ? 1 : 0;
    if (c == I * (W + 1) + 1) return 0;
    return c + 1;
  endfunction

  task automatic chk(string nm, int c,
                     vec_t got, vec_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc%0d got %h exp %h",
                  nm, c, got, exp);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("dut_a", e.c, get_a(), e.v);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("dut_b", e.c, get_b(), e.v);
    end
  end

  task automatic tick(bit s_a, bit a_a,
                      bit s_b, bit a_b);
    ca = adv(ca, s_a, a_a, 4, 16);
    cb = adv(cb, s_b, a_b, 2, 1);
    qa.push_back('{v: model(ca, 4, 16), c: ca});
    qb.push_back('{v: model(cb, 2, 1), c: cb});
    sa = s_a; aa = a_a;
    sb = s_b; ab = a_b;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  task automatic run_out();
    for (int i = 0; i < 100 && ca != 0; i++)
      tick(ca == 10 || ca == 81, 0, cb == 2, 0);
    if (ca != 0) begin
      n_chk++;
      $display("FAIL run_out cyc%0d got busy exp idle", ca);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    sa = 0; aa = 0; sb = 0; ab = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a", 0, get_a(), '0);
    chk("rst_b", 0, get_b(), '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    idle(3);
    tick(1, 1, 1, 1);
    idle(2);

    // Full run; start re-asserted at cycles 10 and 81.
    tick(1, 0, 1, 0);
    run_out();
    tick(1, 0, 1, 0);

    // Abort at cycle 30, then a clean full run.
    for (int i = 0; i < 40 && ca != 30; i++)
      tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    idle(3);
    tick(1, 0, 1, 0);
    tick(0, 0, 0, 1);
    run_out();
    idle(2);

    // Asynchronous reset mid-run.
    tick(1, 0, 1, 0);
    for (int i = 0; i < 30 && ca != 20; i++)
      tick(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_a", ca, get_a(), '0);
    chk("arst_b", cb, get_b(), '0);
    ca = 0;
    cb = 0;
    @(posedge clk);
    #1;
    chk("arst_hold_a", 0, get_a(), '0);
    chk("arst_hold_b", 0, get_b(), '0);
    #1 rst_n = 1'b1;
    idle(2);
    tick(1, 0, 1, 0);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
